// File: rtl/seg_scan_capture.sv
// seg_scan_capture: passive decoder that turns a scanned 4-digit 7-segment drive back into BCD frames.
// Optional feature: define CAPTURE_DP_EN to add the dp port and decimal-point capture.
module seg_scan_capture #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [3:0]  wei,
    input  logic [7:0]  qc,
    input  logic        err_clr,
    output logic [15:0] digits,
    output logic        frame_valid,
    output logic        seg_err,
    output logic        anode_err,
`ifdef CAPTURE_DP_EN
    output logic [3:0]  dp,
`endif
    output logic        stale
);

`ifdef CAPTURE_DP_EN
    localparam int QW = 8;
`else
    localparam int QW = 7;
`endif
    localparam int SW = $clog2(STABLE_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0] STAB_ARM = SW'(STABLE_CYCLES - 2);
    localparam logic [TW-1:0] WD_MAX = TW'(TIMEOUT_CYCLES);

    logic [3:0]    wei_s1, wei_s2;
    logic [QW-1:0] qc_s1, qc_s2;
    logic [QW+3:0] vec_s, vec_q;
    logic [SW-1:0] stab_cnt;
    logic [TW-1:0] wd_cnt;
    logic          accept;
    logic [3:0]    low;
    logic          one_low, multi_low;
    logic [1:0]    idx;
    logic [3:0]    glyph;
    logic          bad_glyph;
    logic          capture;
    logic [15:0]   shadow;
    logic [3:0]    seen;
    logic          full;

`ifndef CAPTURE_DP_EN
    logic unused_dp;
    assign unused_dp = qc[7];
`endif

    // two-flop synchronizers, reset to the blank (all ones) pattern
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            wei_s1 <= '1;
            wei_s2 <= '1;
            qc_s1  <= '1;
            qc_s2  <= '1;
        end else begin
            wei_s1 <= wei;
            wei_s2 <= wei_s1;
            qc_s1  <= qc[QW-1:0];
            qc_s2  <= qc_s1;
        end
    end

    assign vec_s  = {wei_s2, qc_s2};
    assign accept = (vec_s == vec_q) && (stab_cnt == STAB_ARM);

    // dwell counter restarts on any change and saturates so a pattern is accepted only once
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            vec_q    <= '1;
            stab_cnt <= '0;
        end else begin
            vec_q    <= vec_s;
            stab_cnt <= (vec_s != vec_q) ? '0 : (stab_cnt == STAB_MAX) ? stab_cnt : stab_cnt + SW'(1);
        end
    end

    assign low       = ~wei_s2;
    assign multi_low = (low & (low - 4'd1)) != 4'h0;
    assign one_low   = (low != 4'h0) && !multi_low;
    assign idx       = low[0] ? 2'd0 : low[1] ? 2'd1 : low[2] ? 2'd2 : 2'd3;
    assign capture   = accept && one_low;
    assign full      = seen == 4'hF;

    // active-low glyph to BCD; blank maps to F, anything unknown to E
    always_comb begin
        glyph = 4'hE;
        case (qc_s2[6:0])
            7'h40:   glyph = 4'd0;
            7'h79:   glyph = 4'd1;
            7'h24:   glyph = 4'd2;
            7'h30:   glyph = 4'd3;
            7'h19:   glyph = 4'd4;
            7'h12:   glyph = 4'd5;
            7'h02:   glyph = 4'd6;
            7'h78:   glyph = 4'd7;
            7'h00:   glyph = 4'd8;
            7'h10:   glyph = 4'd9;
            7'h7F:   glyph = 4'hF;
            default: glyph = 4'hE;
        endcase
    end

    assign bad_glyph = glyph == 4'hE;

    // fold accepted digits into the shadow frame and publish it once all four positions are seen
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            shadow      <= '1;
            seen        <= '0;
            digits      <= 16'hFFFF;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= full;
            if (full) digits <= shadow;
            seen <= (full ? 4'h0 : seen) | (capture ? 4'b0001 << idx : 4'h0);
            if (capture) shadow[{idx, 2'b00} +: 4] <= glyph;
        end
    end

`ifdef CAPTURE_DP_EN
    logic [3:0] dp_shadow;

    // decimal points travel with their digits and publish with the frame
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            dp_shadow <= '0;
            dp        <= '0;
        end else begin
            if (full) dp <= dp_shadow;
            if (capture) dp_shadow[idx] <= ~qc_s2[7];
        end
    end
`endif

    // sticky error flags; a new error outranks a simultaneous clear
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            seg_err   <= 1'b0;
            anode_err <= 1'b0;
        end else begin
            seg_err   <= (capture && bad_glyph) || (seg_err && !err_clr);
            anode_err <= (accept && multi_low) || (anode_err && !err_clr);
        end
    end

    // watchdog counts cycles since the last accepted pattern and saturates at the timeout
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) wd_cnt <= '0;
        else wd_cnt <= accept ? '0 : (wd_cnt == WD_MAX) ? wd_cnt : wd_cnt + TW'(1);
    end

    assign stale = wd_cnt == WD_MAX;

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: table-driven, directed and randomized self-check of seg_scan_capture
module tb_seg_scan_capture;
    localparam int STABLE  = 16;
    localparam int TIMEOUT = 256;
    localparam logic [6:0] GLYPH [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
`ifdef CAPTURE_DP_EN
    localparam bit DPEN = 1'b1;
`else
    localparam bit DPEN = 1'b0;
`endif

    typedef struct {
        logic [3:0]  w;
        logic [7:0]  q;
        logic        clr;
        int          fv;
        logic [15:0] dig;
        logic        se;
        logic        ae;
    } vec_t;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    logic [3:0] wei = 4'hF;
    logic [7:0] qc = 8'hFF;
    logic err_clr = 1'b0;
    logic [15:0] digits;
    logic frame_valid, seg_err, anode_err, stale;
    logic [3:0] dp_o;

    int checks = 0;
    int errors = 0;
    int fv_cnt = 0;
    int base;
    int exp_frames;
    logic sb_on = 1'b0;
    logic [19:0] exp_q [$];
    vec_t tbl [$];

    logic [15:0] m_sh;
    logic [3:0]  m_dp, m_seen;
    logic        m_se, m_ae;
    logic [11:0] prev_key;

    always #10 clk = ~clk;

    seg_scan_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk),
        .clr_n(clr_n),
        .wei(wei),
        .qc(qc),
        .err_clr(err_clr),
        .digits(digits),
        .frame_valid(frame_valid),
        .seg_err(seg_err),
        .anode_err(anode_err),
`ifdef CAPTURE_DP_EN
        .dp(dp_o),
`endif
        .stale(stale)
    );
`ifndef CAPTURE_DP_EN
    assign dp_o = 4'h0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (clr_n && frame_valid) begin
            fv_cnt++;
            if (sb_on) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rnd_frame: got %0h expected no frame", {dp_o, digits});
                end else chk("rnd_frame", {12'h0, dp_o, digits}, {12'h0, exp_q.pop_front()});
            end
        end
    end

    function automatic logic [3:0] dec(input logic [6:0] c);
        if (c == 7'h7F) return 4'hF;
        for (int i = 0; i < 10; i++) if (GLYPH[i] == c) return 4'(i);
        return 4'hE;
    endfunction

    function automatic logic [11:0] key(input logic [3:0] w, input logic [7:0] q);
        return DPEN ? {w, q} : {w, 1'b0, q[6:0]};
    endfunction

    task automatic add(input logic [3:0] w, input logic [7:0] q, input logic c, input int f,
                       input logic [15:0] d, input logic s, input logic a);
        vec_t v;
        v.w = w; v.q = q; v.clr = c; v.fv = f; v.dig = d; v.se = s; v.ae = a;
        tbl.push_back(v);
    endtask

    task automatic hold(input logic [3:0] w, input logic [7:0] q, input int n);
        wei = w;
        qc = q;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        wei = 4'hF;
        qc = 8'hFF;
        clr_n = 1'b0;
        repeat (3) @(negedge clk);
        clr_n = 1'b1;
    endtask

    task automatic model_accept(input logic [3:0] w, input logic [7:0] q);
        int n;
        int i;
        n = $countones(~w);
        i = 0;
        if (n > 1) m_ae = 1'b1;
        else if (n == 1) begin
            for (int k = 0; k < 4; k++) if (!w[k]) i = k;
            m_sh[4*i +: 4] = dec(q[6:0]);
            m_dp[i] = ~q[7];
            if (dec(q[6:0]) == 4'hE) m_se = 1'b1;
            m_seen[i] = 1'b1;
            if (m_seen == 4'hF) begin
                exp_q.push_back({DPEN ? m_dp : 4'h0, m_sh});
                exp_frames++;
                m_seen = 4'h0;
            end
        end
    endtask

    initial begin
        add(4'b1110, 8'h92, 0, 0, 16'hFFFF, 0, 0);
        add(4'b1101, 8'h99, 0, 0, 16'hFFFF, 0, 0);
        add(4'b1011, 8'hC0, 0, 0, 16'hFFFF, 0, 0);
        add(4'b0111, 8'hC0, 0, 1, 16'h0045, 0, 0);
        add(4'b1111, 8'hFF, 0, 0, 16'h0045, 0, 0);
        add(4'b1110, 8'hF9, 0, 0, 16'h0045, 0, 0);
        add(4'b1101, 8'hA4, 0, 0, 16'h0045, 0, 0);
        add(4'b1011, 8'hFE, 0, 0, 16'h0045, 1, 0);
        add(4'b0111, 8'h90, 0, 1, 16'h9E21, 1, 0);
        add(4'b1100, 8'h99, 1, 0, 16'h9E21, 0, 1);
        add(4'b1011, 8'hF8, 0, 0, 16'h9E21, 0, 1);
        add(4'b0111, 8'hB0, 0, 0, 16'h9E21, 0, 1);
        add(4'b1110, 8'h82, 1, 0, 16'h9E21, 0, 0);
        add(4'b1101, 8'h80, 0, 1, 16'h3786, 0, 0);

        repeat (3) @(negedge clk);
        chk("rst_digits", digits, 16'hFFFF);
        chk("rst_frame_valid", frame_valid, 0);
        chk("rst_seg_err", seg_err, 0);
        chk("rst_anode_err", anode_err, 0);
        chk("rst_stale", stale, 0);
`ifdef CAPTURE_DP_EN
        chk("rst_dp", dp_o, 0);
`endif
        clr_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            base = fv_cnt;
            wei = tbl[i].w;
            qc = tbl[i].q;
            err_clr = tbl[i].clr;
            @(negedge clk);
            err_clr = 1'b0;
            repeat (63) @(negedge clk);
            chk($sformatf("tbl%0d_frames", i), fv_cnt - base, tbl[i].fv);
            chk($sformatf("tbl%0d_digits", i), digits, tbl[i].dig);
            chk($sformatf("tbl%0d_seg_err", i), seg_err, tbl[i].se);
            chk($sformatf("tbl%0d_anode_err", i), anode_err, tbl[i].ae);
            chk($sformatf("tbl%0d_stale", i), stale, 0);
        end

        base = fv_cnt;
        hold(4'b1110, 8'h92, 30);
        hold(4'b1110, 8'hF9, 14);
        hold(4'b1101, 8'h99, 40);
        hold(4'b1011, 8'hC0, 40);
        hold(4'b0111, 8'hC0, 40);
        chk("glitch_frames", fv_cnt - base, 1);
        chk("glitch_digits", digits, 16'h0045);

        hold(4'b1110, 8'hFE, 40);
        chk("seg_err_first", seg_err, 1);
        base = fv_cnt;
        wei = 4'b1101;
        qc = 8'hFE;
        repeat (STABLE + 1) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        repeat (20) @(negedge clk);
        chk("seg_err_set_wins", seg_err, 1);
        hold(4'b1011, 8'hC0, 40);
        hold(4'b0111, 8'hC0, 40);
        chk("bad_frames", fv_cnt - base, 1);
        chk("bad_digits", digits, 16'h00EE);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        chk("seg_err_cleared", seg_err, 0);

        hold(4'b1111, 8'hFF, 220);
        chk("stale_early", stale, 0);
        repeat (100) @(negedge clk);
        chk("stale_set", stale, 1);
        hold(4'b1110, 8'h92, 25);
        chk("stale_cleared", stale, 0);

        base = fv_cnt;
        hold(4'b1101, 8'hF9, 40);
        hold(4'b1011, 8'hA4, 40);
        chk("partial_frames", fv_cnt - base, 0);
        wei = 4'hF;
        qc = 8'hFF;
        clr_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_digits", digits, 16'hFFFF);
        chk("midrst_frame_valid", frame_valid, 0);
        chk("midrst_stale", stale, 0);
        clr_n = 1'b1;
        base = fv_cnt;
        hold(4'b0111, 8'h90, 40);
        chk("postrst_no_early_frame", fv_cnt - base, 0);
        hold(4'b1110, 8'h80, 40);
        hold(4'b1101, 8'hF8, 40);
        hold(4'b1011, 8'h82, 40);
        chk("postrst_frames", fv_cnt - base, 1);
        chk("postrst_digits", digits, 16'h9678);

        do_reset();
        m_seen = 4'h0;
        m_se = 1'b0;
        m_ae = 1'b0;
        m_sh = '1;
        m_dp = '0;
        prev_key = key(4'hF, 8'hFF);
        exp_q.delete();
        exp_frames = 0;
        base = fv_cnt;
        sb_on = 1'b1;
        for (int s = 0; s < 300; s++) begin
            logic [3:0] w;
            logic [7:0] q;
            int len;
            int r;
            bit lng;
            bit clr;
            do begin
                r = $urandom_range(0, 19);
                w = r < 14 ? ~(4'b0001 << $urandom_range(0, 3)) : r < 17 ? 4'hF : 4'($urandom_range(0, 15));
                r = $urandom_range(0, 19);
                q[6:0] = r < 15 ? GLYPH[$urandom_range(0, 9)] : r < 17 ? 7'h7F : 7'($urandom_range(0, 127));
                q[7] = 1'($urandom_range(0, 1));
            end while (key(w, q) == prev_key);
            lng = $urandom_range(0, 3) != 0;
            len = lng ? $urandom_range(STABLE + 4, STABLE + 24) : $urandom_range(1, STABLE - 4);
            clr = $urandom_range(0, 7) == 0;
            if (clr) begin
                m_se = 1'b0;
                m_ae = 1'b0;
            end
            if (lng) model_accept(w, q);
            prev_key = key(w, q);
            wei = w;
            qc = q;
            err_clr = clr;
            @(negedge clk);
            err_clr = 1'b0;
            repeat (len - 1) @(negedge clk);
            if (lng) begin
                chk($sformatf("rnd%0d_seg_err", s), seg_err, m_se);
                chk($sformatf("rnd%0d_anode_err", s), anode_err, m_ae);
                chk($sformatf("rnd%0d_stale", s), stale, 0);
                chk($sformatf("rnd%0d_frames", s), fv_cnt - base, exp_frames);
            end
        end
        sb_on = 1'b0;
        chk("rnd_pending_frames", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg_scan_capture.md
# seg_scan_capture

- Passive monitor on the multiplexed 7-segment drive of the Basys2 seconds-counter display: samples the anode (`wei`) and segment (`qc`) lines and decodes the scanned glyphs back into four BCD digits.
- Publishes a coherent 4-digit frame with a one-cycle strobe.
- Flags undecodable glyphs, illegal anode patterns and a stalled scan.
- Sits beside the display scanner in the top level, on the 50 MHz clock, for self-check and bench scoreboarding.

## Interface
Parameters:
- `STABLE_CYCLES`, 16: cycles the synchronized {wei,qc} must stay unchanged before it is accepted (≥2).
- `TIMEOUT_CYCLES`, 1048576: cycles without an accepted pattern before `stale` asserts.

Ports:
- `clk` in 1: system clock, 50 MHz, rising edge.
- `clr_n` in 1: reset, asynchronous assert, active-low.
- `wei` in 4: anode lines, active-low one-hot; bit 0 = rightmost digit.
- `qc` in 8: segment lines, active-low; qc[6:0] = g,f,e,d,c,b,a; qc[7] = dp.
- `err_clr` in 1: single-cycle pulse that clears `seg_err` and `anode_err`.
- `digits` out 16: captured frame, digit i at [4i+3:4i].
- `frame_valid` out 1: one-cycle pulse when `digits` updates.
- `seg_err` out 1: sticky; an accepted glyph was not in the decode table.
- `anode_err` out 1: sticky; an accepted anode pattern had more than one low bit.
- `stale` out 1: no pattern accepted for `TIMEOUT_CYCLES`.
- `dp` out 4: captured decimal points, active-high. Present only with `CAPTURE_DP_EN`.

## Operation
Input synchronization:
- `wei` and `qc` pass through 2-flop synchronizers.
- Synchronizer reset value is all ones, which is the blank/idle pattern.

Stability filter:
- `stab_cnt` resets to 0 whenever the synchronized 12-bit vector differs from its previous-cycle value.
- Otherwise `stab_cnt` increments, saturating at `STABLE_CYCLES`-1.
- The pattern is accepted exactly once, on the cycle `stab_cnt` first reaches `STABLE_CYCLES`-1. No re-accept occurs until the vector changes.

Accepted-pattern handling, by number of low bits in `wei`:
- Zero low (all high): blanking interval; ignored except that it restarts the stale watchdog.
- Exactly one low, index i:
  - Decode qc[6:0] into `shadow[i]` and set `seen[i]`.
  - With `CAPTURE_DP_EN`, store ~qc[7] into `dp_shadow[i]`.
- Two or more low: set `anode_err`; `shadow` and `seen` are unchanged.

Decode table, qc[6:0] active-low → value:
- 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7, 0x00→8, 0x10→9.
- 0x7F (blank) → 4'hF.
- Any other code → 4'hE and sets `seg_err`.

Frame assembly:
- When `seen` becomes 4'b1111, on the next cycle:
  - `digits` ← `shadow`;
  - `dp` ← `dp_shadow`;
  - `frame_valid` pulses for one cycle;
  - `seen` clears.
- A digit re-accepted before the frame completes overwrites its `shadow` entry; the latest value wins.

Error and stale flags:
- `err_clr` clears both sticky errors. If a set and a clear occur on the same cycle, the set wins.
- The stale watchdog counts cycles since the last accept and saturates.
  - `stale` asserts when the count reaches `TIMEOUT_CYCLES`.
  - `stale` deasserts on the cycle after the next accept.

Reset:
- Reset mid-frame discards `shadow`, `dp_shadow` and `seen`; there is no partial-frame output.

## Timing
Reset values:
- `digits` = 16'hFFFF.
- `frame_valid`, `seg_err`, `anode_err`, `stale`, `dp` = 0.
- `stab_cnt` and the watchdog count = 0.

Latency:
- From an input change to accept: 2 (synchronizer) + `STABLE_CYCLES`-1 cycles.
- From accept to `shadow`/`seen`/error update: registered, 1 cycle.
- From `seen` full to `frame_valid`: 1 cycle.

Glitches:
- Any input glitch shorter than `STABLE_CYCLES` synchronized cycles is never accepted.

Minimum digit dwell:
- Each digit must dwell at least `STABLE_CYCLES`+2 cycles. The 190 Hz scanner provides about 263k cycles per digit.

## Configuration
- `CAPTURE_DP_EN` defined:
  - the `dp` port, `dp_shadow` and decimal-point capture are present;
  - qc[7] participates in the stability compare.
- `CAPTURE_DP_EN` undefined:
  - there is no `dp` port;
  - qc[7] is ignored, including by the stability filter.

## Test plan
- Scan wei=1110/1101/1011/0111 with qc = glyphs 5,4,0,0, 64 cycles each → single `frame_valid`, `digits` = 16'h0045, no errors.
- Toggle qc for 10 cycles mid-dwell with `STABLE_CYCLES`=16 → glitch not accepted, `digits` unchanged after the frame.
- Apply qc=0x7E on digit 2 → `seg_err`=1 and digit 2 = 4'hE in the frame. Pulse `err_clr` on the same cycle as a second bad glyph → `seg_err` stays 1.
- Apply wei=1100 stable → `anode_err`=1 and `seen` unchanged. `err_clr` clears it.
- Hold the inputs constant with `TIMEOUT_CYCLES`=256 → `stale`=1 about 256 cycles after the accept. A new pattern accept → `stale`=0.
- Assert `clr_n` low after 3 digits are accepted, then release and scan 4 digits → exactly one frame, containing only post-reset values.
